// File: rtl/invert_if.sv
// invert_if: bit-serial operand/result pair for the invert block.
//   i : serial operand bit, LSB first (driven by the shift-out source)
//   y : serial two's-complement result bit (consumed by the shift-in sink)
// The invert module keeps its plain i/y ports for drop-in compatibility;
// this interface bundles the pair on the integration side.
interface invert_if;
  logic i;
  logic y;

  modport master (output i, input y);
  modport slave  (input i, output y);
endinterface

// File: rtl/invert.sv
// invert: bit-serial two's-complement unit.
// Operand bits arrive LSB first on i, one per t_clk; the negated stream
// leaves on y in the same cycle (Mealy, zero latency). Bits pass unchanged
// up to and including the first 1; every later bit is inverted.
//
// Ports (positional order i, r, t_clk, y):
//   i     in  serial operand bit, sampled at rising t_clk
//   r     in  asynchronous active-high reset; clears state, y = i while held
//   t_clk in  clock
//   y     out serial result bit
//
// Parameters:
//   WORD_LEN  bits per word (1..65535); only used with INVERT_WORD_RESTART_EN.
//
// Optional feature (macro INVERT_WORD_RESTART_EN):
//   A bit counter restarts the word every WORD_LEN bits so consecutive words
//   stream without a reset between them. Without the macro only r clears the
//   state, so every word must be framed by a reset pulse.
module invert #(
  parameter int unsigned WORD_LEN = 8
) (
  input  logic i,
  input  logic r,
  input  logic t_clk,
  output logic y
);

  typedef enum logic {
    S_PASS   = 1'b0,  // no 1 consumed yet in this word
    S_INVERT = 1'b1   // a 1 has been consumed; invert from here on
  } state_t;

  state_t state;
  state_t state_next;
  logic   seen_one;
  logic   word_end;

  assign seen_one = (state == S_INVERT);

  // Out-of-range WORD_LEN marker; generates no hardware.
  if (WORD_LEN < 1 || WORD_LEN > 65535) begin : g_word_len_out_of_range
  end

`ifdef INVERT_WORD_RESTART_EN
  localparam int unsigned CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LEN - 1);

  logic [CNT_W-1:0] bit_cnt;

  assign word_end = (bit_cnt == LAST_BIT);

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      bit_cnt <= '0;
    end else if (word_end) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end
`else
  assign word_end = 1'b0;
`endif

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state <= S_PASS;
    end else begin
      state <= state_next;
    end
  end

  // The last bit of a word is still output with the pre-clear state; the
  // word-end clear only affects the state seen by the next word's LSB.
  always_comb begin
    state_next = state;
    y          = seen_one ? ~i : i;
    if (i) begin
      state_next = S_INVERT;
    end
    if (word_end) begin
      state_next = S_PASS;
    end
  end

endmodule

// File: tb/tb_invert.sv
// tb_invert: self-checking bench for invert. Expected result bits are pushed
// to a queue as each operand bit is driven and popped/compared mid-cycle.
module tb_invert;

`ifdef INVERT_WORD_RESTART_EN
  localparam int unsigned WL = 4;
`else
  localparam int unsigned WL = 8;
`endif

  logic t_clk = 1'b0;
  logic r     = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  invert_if bus ();

  invert #(.WORD_LEN(WL)) dut (
    .i     (bus.i),
    .r     (r),
    .t_clk (t_clk),
    .y     (bus.y)
  );

  always #5 t_clk = ~t_clk;

  // Async reset pulse between edges; i is driven low before release.
  task automatic pulse_reset();
    bus.i = 1'b0;
    r = 1'b1;
    #1;
    r = 1'b0;
  endtask

  // Stream one WL-bit word; the expected stream is the arithmetic negation.
  task automatic stream_word(input logic [15:0] w, input string name);
    logic [15:0] neg;
    logic        exp;
    neg = ~w + 16'd1;
    for (int k = 0; k < int'(WL); k++) begin
      exp_q.push_back(neg[k]);
      bus.i = w[k];
      #4;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.y !== exp) begin
        n_fail++;
        $display("FAIL %s w=0x%0h bit %0d: y=%b expected %b", name, w, k, bus.y, exp);
      end
      @(posedge t_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic exp;
    r = 1'b1;
    @(posedge t_clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(k[0]);
      bus.i = k[0];
      #4;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.y !== exp) begin
        n_fail++;
        $display("FAIL reset_passthru step %0d: y=%b expected %b", k, bus.y, exp);
      end
      @(posedge t_clk);
      #1;
    end
    bus.i = 1'b0;
    r = 1'b0;
  endtask

  task automatic test_words();
    logic [15:0] w;
    logic [15:0] edge_words[4] = '{16'h000C, 16'h0001, 16'h0000, 16'h0080};
    for (int n = 0; n < 4; n++) begin
      pulse_reset();
      stream_word(edge_words[n], "edge_word");
    end
    for (int n = 0; n < 4; n++) begin
      w = 16'($urandom_range(0, 255));
      pulse_reset();
      stream_word(w, "random_word");
    end
  endtask

  task automatic test_reset_mid_word();
    logic ib[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic eb[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        // Reset asserted and released with no clock edge in between.
        r = 1'b1;
        #2;
        r = 1'b0;
      end
      exp_q.push_back(eb[k]);
      bus.i = ib[k];
      #4;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.y !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_word bit %0d: y=%b expected %b", k, bus.y, exp);
      end
      @(posedge t_clk);
      #1;
    end
  endtask

`ifndef INVERT_WORD_RESTART_EN
  task automatic test_sticky();
    logic b;
    logic exp;
    pulse_reset();
    for (int k = 0; k < 24; k++) begin
      if (k < 3) begin
        b = 1'b0;
        exp_q.push_back(1'b0);
      end else if (k == 3) begin
        b = 1'b1;
        exp_q.push_back(1'b1);
      end else begin
        b = 1'($urandom_range(0, 1));
        exp_q.push_back(~b);
      end
      bus.i = b;
      #4;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.y !== exp) begin
        n_fail++;
        $display("FAIL sticky bit %0d: y=%b expected %b", k, bus.y, exp);
      end
      @(posedge t_clk);
      #1;
    end
  endtask
`else
  task automatic test_back_to_back();
    pulse_reset();
    stream_word(16'h0002, "back_to_back");
    stream_word(16'h0003, "back_to_back");
    stream_word(16'h0008, "back_to_back");
    stream_word(16'h0005, "back_to_back");
  endtask
`endif

  initial begin
    bus.i = 1'b0;
    test_reset();
    test_words();
    test_reset_mid_word();
`ifndef INVERT_WORD_RESTART_EN
    test_sticky();
`else
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
